// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
//   Central stall/flush controller for the 5-stage MIPS pipeline. Merges the
//   stall requests from ID, EX and MEM into a per-stage stop vector, sequences
//   exception flushes (waiting out a busy MEM stage first) and runs a sticky
//   stall watchdog.
//
// Ports
//   CLK, RST        clock; synchronous active-high reset
//   ID_STALL_REQ    load-use hazard request (level)
//   EX_STALL_REQ    multi-cycle EX operation busy (level)
//   MEM_STALL_REQ   memory access not complete (level)
//   EXC_REQ         exception pulse from MEM stage
//   EXC_PC          handler/return address accompanying EXC_REQ
//   STALL_O[5:0]    stop per stage: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
//   FLUSH_O         clear all pipeline registers this cycle (registered)
//   NEW_PC_O        PC to load while FLUSH_O=1 (registered, holds otherwise)
//   TIMEOUT_O       sticky watchdog flag, cleared only by RST
//
// Optional feature (macro STALL_PERF_CNT_EN)
//   PERF_STALL_CNT  32-bit count of cycles with STALL_O[2]=1
//   PERF_FLUSH_CNT  16-bit count of FLUSH states
module pipe_stall_ctrl #(
  parameter int unsigned MAX_STALL = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ID_STALL_REQ,
  input  logic        EX_STALL_REQ,
  input  logic        MEM_STALL_REQ,
  input  logic        EXC_REQ,
  input  logic [31:0] EXC_PC,
  output logic [5:0]  STALL_O,
  output logic        FLUSH_O,
  output logic [31:0] NEW_PC_O,
  output logic        TIMEOUT_O
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] PERF_STALL_CNT,
  output logic [15:0] PERF_FLUSH_CNT
`endif
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FLUSH_PEND = 2'd1,
    FLUSH      = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STALL);

  state_t             state_q, state_d;
  logic [31:0]        exc_pc_q, exc_pc_d;
  logic [5:0]         run_stall;
  logic [5:0]         stall;
  logic [CNT_W-1:0]   cnt_q;

  always_comb begin
    state_d   = state_q;
    exc_pc_d  = exc_pc_q;
    stall     = '0;

    // Highest requesting stage wins; WB is never stopped.
    if (MEM_STALL_REQ)     run_stall = 6'b011111;
    else if (EX_STALL_REQ) run_stall = 6'b001111;
    else if (ID_STALL_REQ) run_stall = 6'b000111;
    else                   run_stall = 6'b000000;

    case (state_q)
      RUN: begin
        stall = run_stall;
        if (EXC_REQ) begin
          exc_pc_d = EXC_PC;
          state_d  = MEM_STALL_REQ ? FLUSH_PEND : FLUSH;
        end
      end
      FLUSH_PEND: begin
        // Hold everything up to MEM until the outstanding access completes;
        // later exceptions are ignored so the first PC is kept.
        stall = 6'b011111;
        if (!MEM_STALL_REQ) state_d = FLUSH;
      end
      FLUSH: begin
        stall   = '0;
        state_d = RUN;
      end
      default: begin
        stall   = '0;
        state_d = RUN;
      end
    endcase

    if (RST) stall = '0;
  end

  assign STALL_O = stall;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= RUN;
      exc_pc_q  <= '0;
      FLUSH_O   <= 1'b0;
      NEW_PC_O  <= '0;
      cnt_q     <= '0;
      TIMEOUT_O <= 1'b0;
    end else begin
      state_q  <= state_d;
      exc_pc_q <= exc_pc_d;
      // Registered so FLUSH_O/NEW_PC_O are valid during the FLUSH state itself.
      FLUSH_O  <= (state_d == FLUSH);
      if (state_d == FLUSH) NEW_PC_O <= exc_pc_d;

      if (stall == 6'b000000)  cnt_q <= '0;
      else if (cnt_q != MAX_CNT) cnt_q <= cnt_q + 1'b1;

      if (cnt_q == MAX_CNT) TIMEOUT_O <= 1'b1;
    end
  end

`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      PERF_STALL_CNT <= '0;
      PERF_FLUSH_CNT <= '0;
    end else begin
      if (stall[2])          PERF_STALL_CNT <= PERF_STALL_CNT + 1'b1;
      if (state_q == FLUSH)  PERF_FLUSH_CNT <= PERF_FLUSH_CNT + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        ID_STALL_REQ = 1'b0;
  logic        EX_STALL_REQ = 1'b0;
  logic        MEM_STALL_REQ = 1'b0;
  logic        EXC_REQ = 1'b0;
  logic [31:0] EXC_PC = '0;
  logic [5:0]  STALL_O;
  logic        FLUSH_O;
  logic [31:0] NEW_PC_O;
  logic        TIMEOUT_O;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] PERF_STALL_CNT;
  logic [15:0] PERF_FLUSH_CNT;
`endif

  pipe_stall_ctrl #(.MAX_STALL(4), .CNT_W(16)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .ID_STALL_REQ  (ID_STALL_REQ),
    .EX_STALL_REQ  (EX_STALL_REQ),
    .MEM_STALL_REQ (MEM_STALL_REQ),
    .EXC_REQ       (EXC_REQ),
    .EXC_PC        (EXC_PC),
    .STALL_O       (STALL_O),
    .FLUSH_O       (FLUSH_O),
    .NEW_PC_O      (NEW_PC_O),
    .TIMEOUT_O     (TIMEOUT_O)
`ifdef STALL_PERF_CNT_EN
    ,
    .PERF_STALL_CNT(PERF_STALL_CNT),
    .PERF_FLUSH_CNT(PERF_FLUSH_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [5:0]  stall;
    logic        flush;
    logic        chk_pc;
    logic [31:0] pc;
    logic        chk_to;
    logic        to;
  } exp_t;

  typedef struct {
    logic       id;
    logic       ex;
    logic       mem;
    logic [5:0] stall;
  } vec_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t mk(input string n, input logic [5:0] s, input logic f,
                              input logic cp, input logic [31:0] p,
                              input logic ct, input logic t);
    exp_t e;
    e.name = n; e.stall = s; e.flush = f; e.chk_pc = cp; e.pc = p;
    e.chk_to = ct; e.to = t;
    return e;
  endfunction

  task automatic check_front();
    exp_t e;
    if (sbq.size() == 0) begin
      errors++; checks++;
      $display("FAIL scoreboard_empty: no expected entry at %0t", $time);
      return;
    end
    e = sbq.pop_front();
    checks++;
    if (STALL_O !== e.stall) begin
      errors++;
      $display("FAIL %s stall: got %b want %b", e.name, STALL_O, e.stall);
    end
    checks++;
    if (FLUSH_O !== e.flush) begin
      errors++;
      $display("FAIL %s flush: got %b want %b", e.name, FLUSH_O, e.flush);
    end
    if (e.chk_pc) begin
      checks++;
      if (NEW_PC_O !== e.pc) begin
        errors++;
        $display("FAIL %s new_pc: got %h want %h", e.name, NEW_PC_O, e.pc);
      end
    end
    if (e.chk_to) begin
      checks++;
      if (TIMEOUT_O !== e.to) begin
        errors++;
        $display("FAIL %s timeout: got %b want %b", e.name, TIMEOUT_O, e.to);
      end
    end
  endtask

  // One clock cycle: drive just after the edge, queue the expectation,
  // compare on the falling edge.
  task automatic cyc(input logic rst, input logic id, input logic ex, input logic mem,
                     input logic exc, input logic [31:0] pc, input exp_t e);
    @(posedge CLK);
    #1;
    RST = rst; ID_STALL_REQ = id; EX_STALL_REQ = ex; MEM_STALL_REQ = mem;
    EXC_REQ = exc; EXC_PC = pc;
    sbq.push_back(e);
    @(negedge CLK);
    check_front();
  endtask

  task automatic do_reset(input string n);
    cyc(1, 0, 0, 0, 0, 32'h0, mk({n, "_in_rst"}, 6'b0, 1'b0, 0, 32'h0, 0, 1'b0));
    cyc(0, 0, 0, 0, 0, 32'h0, mk({n, "_after_rst"}, 6'b0, 1'b0, 1, 32'h0, 1, 1'b0));
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1, 0, 0, 6'b000111};
    vecs[1]  = '{0, 0, 0, 6'b000000};
    vecs[2]  = '{1, 1, 0, 6'b001111};
    vecs[3]  = '{1, 1, 0, 6'b001111};
    vecs[4]  = '{1, 1, 0, 6'b001111};
    vecs[5]  = '{1, 1, 1, 6'b011111};
    vecs[6]  = '{1, 1, 0, 6'b001111};
    vecs[7]  = '{1, 0, 0, 6'b000111};
    vecs[8]  = '{0, 0, 0, 6'b000000};
    vecs[9]  = '{0, 1, 1, 6'b011111};
    vecs[10] = '{0, 0, 1, 6'b011111};
    vecs[11] = '{0, 0, 0, 6'b000000};

    do_reset("reset");

    // Stall vectors and priority
    for (int unsigned i = 0; i < 12; i++)
      cyc(0, vecs[i].id, vecs[i].ex, vecs[i].mem, 0, 32'h0,
          mk($sformatf("vec%0d", i), vecs[i].stall, 1'b0, 0, 32'h0, 0, 1'b0));

    // Immediate flush, with a concurrent ID request
    do_reset("pre_imm");
    cyc(0, 1, 0, 0, 1, 32'hBFC00380, mk("imm_n", 6'b000111, 1'b0, 0, 32'h0, 0, 1'b0));
    cyc(0, 1, 1, 0, 0, 32'h0, mk("imm_n1", 6'b000000, 1'b1, 1, 32'hBFC00380, 0, 1'b0));
    cyc(0, 0, 0, 0, 0, 32'h0, mk("imm_n2", 6'b000000, 1'b0, 1, 32'hBFC00380, 0, 1'b0));
    cyc(0, 1, 0, 0, 0, 32'h0, mk("imm_n3", 6'b000111, 1'b0, 1, 32'hBFC00380, 0, 1'b0));

    // Deferred flush with a second exception during the wait
    do_reset("pre_def");
    cyc(0, 0, 0, 1, 1, 32'h80000180, mk("def_n", 6'b011111, 1'b0, 0, 32'h0, 0, 1'b0));
    cyc(0, 1, 0, 1, 0, 32'h0, mk("def_w1", 6'b011111, 1'b0, 0, 32'h0, 0, 1'b0));
    cyc(0, 0, 1, 1, 1, 32'h0, mk("def_w2", 6'b011111, 1'b0, 0, 32'h0, 0, 1'b0));
    cyc(0, 0, 0, 1, 0, 32'h0, mk("def_w3", 6'b011111, 1'b0, 0, 32'h0, 0, 1'b0));
    cyc(0, 1, 1, 1, 0, 32'h0, mk("def_w4", 6'b011111, 1'b0, 0, 32'h0, 0, 1'b0));
    cyc(0, 0, 0, 0, 0, 32'h0, mk("def_memdrop", 6'b011111, 1'b0, 0, 32'h0, 0, 1'b0));
    cyc(0, 1, 1, 0, 0, 32'h0, mk("def_flush", 6'b000000, 1'b1, 1, 32'h80000180, 0, 1'b0));
    cyc(0, 0, 0, 0, 0, 32'h0, mk("def_after", 6'b000000, 1'b0, 1, 32'h80000180, 0, 1'b0));

    // Watchdog with MAX_STALL=4: trips in cycle 5 of a held stall and sticks
    do_reset("pre_wd");
    for (int unsigned i = 0; i < 10; i++)
      cyc(0, 0, 1, 0, 0, 32'h0,
          mk($sformatf("wd%0d", i), 6'b001111, 1'b0, 0, 32'h0, 1, (i >= 5)));
    for (int unsigned i = 0; i < 3; i++)
      cyc(0, 0, 0, 0, 0, 32'h0,
          mk($sformatf("wd_idle%0d", i), 6'b000000, 1'b0, 0, 32'h0, 1, 1'b1));
    do_reset("wd_clear");

    // Reset while a flush is pending discards it
    cyc(0, 0, 0, 1, 1, 32'h12345678, mk("rp_exc", 6'b011111, 1'b0, 0, 32'h0, 0, 1'b0));
    cyc(0, 0, 0, 1, 0, 32'h0, mk("rp_wait", 6'b011111, 1'b0, 0, 32'h0, 0, 1'b0));
    cyc(1, 0, 0, 1, 0, 32'h0, mk("rp_rst", 6'b000000, 1'b0, 0, 32'h0, 0, 1'b0));
    cyc(0, 0, 0, 0, 0, 32'h0, mk("rp_post0", 6'b000000, 1'b0, 1, 32'h0, 1, 1'b0));
`ifdef STALL_PERF_CNT_EN
    checks++;
    if (PERF_STALL_CNT !== 32'd0) begin
      errors++;
      $display("FAIL perf_stall_rst: got %0d want 0", PERF_STALL_CNT);
    end
    checks++;
    if (PERF_FLUSH_CNT !== 16'd0) begin
      errors++;
      $display("FAIL perf_flush_rst: got %0d want 0", PERF_FLUSH_CNT);
    end
`endif
    for (int unsigned i = 1; i < 4; i++)
      cyc(0, 0, 0, 0, 0, 32'h0,
          mk($sformatf("rp_post%0d", i), 6'b000000, 1'b0, 1, 32'h0, 0, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Produces the per-stage STALL vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb. id_ex takes slice STALL_O[3:2] as its STALL[1:0].
- Collects stall requests from ID (load-use), EX (multi-cycle mul/div) and MEM (memory wait).
- Sequences exception flushes, including waiting out a busy MEM stage before flushing.
- Provides a stall watchdog.

Parameters:
- MAX_STALL, 64, consecutive stalled cycles at which the watchdog trips (range 2..65535).
- CNT_W, 16, width of the internal stall-run counter; must satisfy 2^CNT_W > MAX_STALL.

Ports:
- CLK  in  1  clock
- RST  in  1  reset; synchronous, active-high (`RST_EN`)
- ID_STALL_REQ  in  1  load-use hazard request, level
- EX_STALL_REQ  in  1  multi-cycle EX operation busy, level
- MEM_STALL_REQ  in  1  memory access not complete, level
- EXC_REQ  in  1  exception detected in MEM stage, single-cycle pulse
- EXC_PC  in  32  handler/return address accompanying EXC_REQ
- STALL_O  out  6  stop per stage: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = `STOP`
- FLUSH_O  out  1  clear all pipeline registers this cycle
- NEW_PC_O  out  32  PC to load while FLUSH_O=1
- TIMEOUT_O  out  1  sticky watchdog flag

Behaviour:
- Reset, synchronous, on the next CLK edge with RST=1:
  - state=RUN, FLUSH_O=0, NEW_PC_O=0, TIMEOUT_O=0.
  - Counter=0, latched EXC_PC=0.
  - STALL_O=0 during reset.
  - Reset mid-FLUSH_PEND discards the pending exception.
- STALL_O is combinational from the current state and the requests, so a stalled stage holds in the same cycle the request is raised.
- FLUSH_O and NEW_PC_O are registered outputs.
- In RUN, the highest requesting stage wins. A request from stage k stops stages 0..k:
  - MEM_STALL_REQ → 6'b011111
  - else EX_STALL_REQ → 6'b001111
  - else ID_STALL_REQ → 6'b000111
  - else 6'b000000
  - WB (bit5) is never stopped.
- States:
  - RUN
    - EXC_REQ=1 and MEM_STALL_REQ=0: latch EXC_PC → FLUSH.
    - EXC_REQ=1 and MEM_STALL_REQ=1: latch EXC_PC → FLUSH_PEND.
    - STALL_O that cycle follows the normal request rule.
  - FLUSH_PEND
    - STALL_O=6'b011111 regardless of ID/EX requests.
    - Leave for FLUSH on the first cycle MEM_STALL_REQ=0.
    - Further EXC_REQ pulses are ignored; the first latched EXC_PC is kept.
  - FLUSH
    - FLUSH_O=1 and NEW_PC_O=latched PC; both are registered, so visible in the cycle of this state.
    - STALL_O=0 and all requests are ignored.
    - EXC_REQ is ignored.
    - Next state is RUN unconditionally.
- Exception latency: EXC_REQ in cycle N with MEM idle → FLUSH_O=1 in cycle N+1 for exactly 1 cycle. With MEM busy, FLUSH_O follows 1 cycle after MEM_STALL_REQ falls.
- FLUSH_O=0 and NEW_PC_O retains its last value outside FLUSH.
- Watchdog:
  - Counter increments each cycle STALL_O!=0 and clears to 0 on any cycle STALL_O==0 (including FLUSH).
  - It saturates at MAX_STALL.
  - When the counter equals MAX_STALL, TIMEOUT_O is set on the next edge.
  - TIMEOUT_O is cleared only by RST.
  - Example: a stall held continuously from cycle 0 sets TIMEOUT_O in cycle MAX_STALL+1.
- Simultaneous events: EXC_REQ in the same cycle as any stall request still follows the RUN rule above. The stall vector for that cycle is the normal request-based one.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- When defined:
  - Adds output PERF_STALL_CNT (32 bits), a free-running count of cycles with STALL_O[2]=1 (ID stopped).
  - The count wraps at 2^32, resets to 0 on RST, and is not cleared by FLUSH.
  - Adds output PERF_FLUSH_CNT (16 bits), which increments once per FLUSH state, wraps, and resets to 0.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Basic stall vectors: after reset, pulse ID_STALL_REQ for 1 cycle → STALL_O=6'b000111 in the same cycle, then 0. Hold EX_STALL_REQ for 3 cycles with ID_STALL_REQ=1 → STALL_O=6'b001111 for all 3 cycles.
- Priority: assert all three requests → STALL_O=6'b011111. Drop MEM → 6'b001111. Drop EX → 6'b000111.
- Immediate flush: EXC_REQ=1, EXC_PC=32'hBFC00380, MEM idle in cycle N → cycle N+1: FLUSH_O=1, NEW_PC_O=32'hBFC00380, STALL_O=0. Cycle N+2: FLUSH_O=0.
- Deferred flush:
  - Stimulus: EXC_REQ with EXC_PC=32'h80000180 while MEM_STALL_REQ=1 for 4 more cycles; a second EXC_REQ with EXC_PC=32'h0 during the wait.
  - Response: STALL_O=6'b011111 throughout the wait; FLUSH_O=1 with NEW_PC_O=32'h80000180 one cycle after MEM drops.
- Watchdog: MAX_STALL=4, EX_STALL_REQ held 10 cycles → TIMEOUT_O rises in cycle 5 and stays 1 after the request drops, until RST.
- Reset mid-operation: RST during FLUSH_PEND → next cycle state RUN, FLUSH_O=0, no flush ever emitted. With STALL_PERF_CNT_EN, PERF counters read 0.
